// File: rtl/input_ram_sequencer.sv
// input_ram_sequencer
//   Reads a 1-bit-wide input-sample RAM (synchronous read, registered address)
//   from address 0 to NUM_INPUTS-1. Each bit goes to the neuron/MAC stage with
//   its index over a valid/ready handshake. The sequencer also counts the
//   1-bits (input spikes) in the sample.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        1-cycle request to stream one sample (ignored unless idle)
//   abort        synchronous cancel back to idle; takes priority over start
//   ram_addr     RAM read address (driven combinationally)
//   ram_q        RAM data for the address registered on the previous edge
//   bit_valid    bit_data/bit_index valid
//   bit_ready    downstream accept; a transfer occurs when bit_valid & bit_ready
//   bit_data     streamed input bit
//   bit_index    address of bit_data
//   busy         high while priming or streaming
//   done         1-cycle pulse after the last transfer
//   spike_count  number of 1-bits transferred in the current/last sample
module input_ram_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_INPUTS = 784,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_q,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  bit_data,
  output logic [ADDR_WIDTH-1:0] bit_index,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  spike_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  spike_count_q, spike_count_d;
  logic                  fire;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spike_count_d = spike_count_q;
    ram_addr      = '0;
    bit_valid     = 1'b0;
    bit_data      = 1'b0;
    bit_index     = '0;
    busy          = 1'b0;
    done          = 1'b0;
    fire          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_PRIME;
          idx_d         = '0;
          spike_count_d = '0;
        end
      end

      // Address 0 is presented for one edge so ram_q holds ram[0] on STREAM entry.
      S_PRIME: begin
        busy    = 1'b1;
        state_d = S_STREAM;
      end

      // The address runs one step ahead only on a transfer, so ram_q stays
      // stable during backpressure. On the final transfer the address stays
      // at the last index and never runs past the sample.
      S_STREAM: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_data  = ram_q;
        bit_index = idx_q;
        ram_addr  = idx_q;
        fire      = bit_ready;
        if (fire) begin
          spike_count_d = spike_count_q + CNT_WIDTH'(ram_q);
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + ADDR_WIDTH'(1);
            ram_addr = idx_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // An abort leaves the partial count and the index unchanged.
    if (abort) begin
      state_d       = S_IDLE;
      idx_d         = idx_q;
      spike_count_d = spike_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_input_ram_sequencer.sv
module tb_input_ram_sequencer;
  localparam int AW = 10;
  localparam int N  = 784;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic bit_ready = 1'b0;
  logic [AW-1:0] ram_addr, bit_index;
  logic ram_q, bit_valid, bit_data, busy, done;
  logic [CW-1:0] spike_count;

  always #5 clk = ~clk;

  input_ram_sequencer #(.ADDR_WIDTH(AW), .NUM_INPUTS(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ram_addr(ram_addr), .ram_q(ram_q),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_data(bit_data),
    .bit_index(bit_index), .busy(busy), .done(done), .spike_count(spike_count)
  );

  // Behavioural RAM: synchronous read through a registered address.
  logic mem [0:(1<<AW)-1];
  logic [AW-1:0] raddr_r = '0;
  always @(posedge clk) raddr_r <= ram_addr;
  assign ram_q = mem[raddr_r];

  // Second instance for the single-input boundary.
  logic start1 = 1'b0;
  logic [3:0] ram_addr1, bit_index1, raddr1_r = '0;
  logic ram_q1, bit_valid1, bit_data1, busy1, done1;
  logic [1:0] spike_count1;
  logic mem1 = 1'b1;
  always @(posedge clk) raddr1_r <= ram_addr1;
  assign ram_q1 = (raddr1_r == 4'd0) ? mem1 : 1'bx;

  input_ram_sequencer #(.ADDR_WIDTH(4), .NUM_INPUTS(1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .ram_addr(ram_addr1), .ram_q(ram_q1),
    .bit_valid(bit_valid1), .bit_ready(1'b1), .bit_data(bit_data1),
    .bit_index(bit_index1), .busy(busy1), .done(done1), .spike_count(spike_count1)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          d;
  } item_t;

  item_t exp_q[$];
  int    exp_spk[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    last_fire = -10;
  int    done_seen = 0;
  int    rdy_mode = 2;    // 0: always ready, 1: random, 2: never, 3: stall at stop_idx
  int    stop_idx = 0;
  item_t mon_e;
  int    mon_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Ready driver, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: bit_ready = 1'b1;
      1: bit_ready = 1'($urandom_range(0, 1));
      3: bit_ready = (int'(bit_index) != stop_idx);
      default: bit_ready = 1'b0;
    endcase
  end

  // Monitor: pops the expected stream whenever the DUT transfers or finishes.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (ram_addr > AW'(N - 1)) check("ram_addr_range", 32'(ram_addr), N - 1);
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 32'(bit_index), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_index", 32'(bit_index), 32'(mon_e.idx));
          check("xfer_data", 32'(bit_data), 32'(mon_e.d));
        end
        last_fire = cyc;
      end
      if (bit_valid && !bit_ready) check("stall_addr_hold", 32'(ram_addr), 32'(bit_index));
      if (done) begin
        done_seen++;
        check("done_after_last", 32'(cyc), 32'(last_fire + 1));
        check("done_queue_empty", 32'(exp_q.size()), 0);
        if (exp_spk.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          mon_s = exp_spk.pop_front();
          check("spike_count", 32'(spike_count), 32'(mon_s));
        end
      end
    end
  end

  task automatic fill(input int mode);
    for (int i = 0; i < (1 << AW); i++) begin
      case (mode)
        0: mem[i] = 1'b0;
        1: mem[i] = i[0];
        default: mem[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  function automatic int popcount(input int upto);
    int s = 0;
    for (int i = 0; i < upto; i++) s += int'(mem[i]);
    return s;
  endfunction

  task automatic push_sample();
    for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), mem[i]});
    exp_spk.push_back(popcount(N));
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_budget"}, 32'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_index(input string name, input int target);
    int n = 0;
    while (!(bit_valid && int'(bit_index) == target) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, 32'(bit_index), 32'(target));
  endtask

  initial begin
    int d0, vbad, vcnt, dcnt, vcyc, dcyc;
    #1;
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_valid", 32'(bit_valid), 0);
    check("rst_busy_done", 32'({busy, done, bit_data}), 0);
    check("rst_spike", 32'(spike_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;

    // 1: all-zero RAM, ready held high: exact latency and throughput.
    fill(0);
    push_sample();
    do_start();
    @(negedge clk);
    check("prime_valid", 32'(bit_valid), 0);
    check("prime_busy", 32'(busy), 1);
    vbad = 0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (!bit_valid || done) vbad++;
    end
    check("consecutive_valid_gaps", 32'(vbad), 0);
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_valid_after", 32'(bit_valid), 0);
    check("t1_busy_after", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // 2: alternating pattern; a start pulse mid-stream must be ignored.
    fill(1);
    check("model_alt_popcount", 32'(popcount(N)), 392);
    push_sample();
    d0 = done_seen;
    do_start();
    repeat (200) @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    wait_done("t2", 5000);
    check("t2_single_done", 32'(done_seen - d0), 1);

    // 3: five-cycle stall at index 100.
    fill(2);
    push_sample();
    stop_idx = 100;
    rdy_mode = 3;
    do_start();
    wait_index("t3", 100);
    for (int k = 0; k < 5; k++) begin
      check("t3_index_frozen", 32'(bit_index), 100);
      check("t3_addr_frozen", 32'(ram_addr), 100);
      check("t3_data_frozen", 32'(bit_data), 32'(mem[100]));
      if (k < 4) @(negedge clk);
    end
    rdy_mode = 0;
    wait_done("t3", 5000);

    // 4: abort at index 300 (held stalled there), then restream.
    fill(2);
    push_sample();
    stop_idx = 300;
    rdy_mode = 3;
    do_start();
    wait_index("t4", 300);
    d0 = done_seen;
    #2 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    exp_spk.delete();
    @(negedge clk);
    check("t4_idle_busy", 32'(busy), 0);
    check("t4_idle_valid", 32'(bit_valid), 0);
    check("t4_spike_hold", 32'(spike_count), 32'(popcount(300)));
    repeat (5) @(negedge clk);
    check("t4_no_done", 32'(done_seen - d0), 0);
    // abort and start together in idle: abort wins.
    #2 begin abort = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin abort = 1'b0; start = 1'b0; end
    repeat (2) @(negedge clk);
    check("abort_beats_start", 32'(busy), 0);
    rdy_mode = 1;
    fill(2);
    push_sample();
    do_start();
    wait_done("t4_restream", 5000);

    // 5: asynchronous reset mid-stream.
    rdy_mode = 0;
    push_sample();
    do_start();
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_addr", 32'(ram_addr), 0);
    check("t5_valid", 32'(bit_valid), 0);
    check("t5_index_data", 32'({bit_index, bit_data}), 0);
    check("t5_busy_done", 32'({busy, done}), 0);
    check("t5_spike", 32'(spike_count), 0);
    exp_q.delete();
    exp_spk.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 1;
    fill(2);
    push_sample();
    do_start();
    wait_done("t5_after", 5000);

    // 6: NUM_INPUTS = 1 instance.
    vcnt = 0; dcnt = 0; vcyc = -1; dcyc = -2;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ram_addr1 != 4'd0) check("t6_addr_zero", 32'(ram_addr1), 0);
      if (bit_valid1) begin
        vcnt++; vcyc = k;
        check("t6_index", 32'(bit_index1), 0);
        check("t6_data", 32'(bit_data1), 1);
      end
      if (done1) begin dcnt++; dcyc = k; end
    end
    check("t6_valid_cycles", 32'(vcnt), 1);
    check("t6_done_pulses", 32'(dcnt), 1);
    check("t6_done_follows", 32'(dcyc), 32'(vcyc + 1));
    check("t6_spike", 32'(spike_count1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
